// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - receiver for a 4-digit multiplexed seven-segment scan bus
// Filters each scanned digit for stability, decodes it, and emits complete 16-bit frames.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anodes,
  input  logic [6:0]  segments,
  output logic [15:0] data,
  output logic        valid,
  output logic [3:0]  digit_err,
  output logic        stale
);

  localparam logic [7:0]  STABLE_M1 = 8'(STABLE_CYCLES - 1);
  localparam logic [19:0] TO_LIM    = 20'(TIMEOUT);
  localparam logic [19:0] TO_M1     = 20'(TIMEOUT - 1);

  // Returns {invalid, nibble}; unknown patterns decode to 0 with invalid set.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1111110: seg_decode = 5'h00;
      7'b0110000: seg_decode = 5'h01;
      7'b1101101: seg_decode = 5'h02;
      7'b1111001: seg_decode = 5'h03;
      7'b0110011: seg_decode = 5'h04;
      7'b1011011: seg_decode = 5'h05;
      7'b1011111: seg_decode = 5'h06;
      7'b1110000: seg_decode = 5'h07;
      7'b1111111: seg_decode = 5'h08;
      7'b1111011: seg_decode = 5'h09;
      7'b1110111: seg_decode = 5'h0A;
      7'b0011111: seg_decode = 5'h0B;
      7'b1001110: seg_decode = 5'h0C;
      7'b0111101: seg_decode = 5'h0D;
      7'b1001111: seg_decode = 5'h0E;
      7'b1000111: seg_decode = 5'h0F;
      default:    seg_decode = 5'h10;
    endcase
  endfunction

  logic [10:0] in_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  seen_q, seen_d;
  logic [19:0] to_q, to_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [3:0]  derr_q, derr_d;
  logic        stale_q, stale_d;

  logic [10:0] raw;
  logic        same, onehot, capture, complete, expire;
  logic [4:0]  dec;
  logic [3:0]  an_q;

  always_comb begin
    raw      = {anodes, segments};
    same     = (raw == in_q);
    an_q     = in_q[10:7];
    onehot   = (an_q != 4'b0000) && ((an_q & (an_q - 4'd1)) == 4'b0000);
    dec      = seg_decode(in_q[6:0]);
    capture  = same && (cnt_q == STABLE_M1) && onehot && armed_q;
    complete = (seen_q == 4'b1111);
    // A capture on the expiry edge keeps the frame alive.
    expire   = !capture && (to_q == TO_M1);

    cnt_d   = same ? ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1) : 8'd0;
    armed_d = !same ? 1'b1 : (capture ? 1'b0 : armed_q);
    to_d    = capture ? 20'd0 : ((to_q == TO_LIM) ? to_q : to_q + 20'd1);

    shadow_d = shadow_q;
    err_d    = err_q;
    seen_d   = seen_q;
    if (complete || expire) begin
      seen_d = 4'b0000;
      err_d  = 4'b0000;
    end
    if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (an_q[i]) begin
          shadow_d[4*i +: 4] = dec[3:0];
          err_d[i]           = dec[4];
          seen_d[i]          = 1'b1;
        end
      end
    end

    data_d  = complete ? shadow_q : data_q;
    derr_d  = complete ? err_q : derr_q;
    valid_d = complete;
    stale_d = capture ? 1'b0 : (expire ? 1'b1 : stale_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q     <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b1;
      shadow_q <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      to_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      derr_q   <= '0;
      stale_q  <= 1'b0;
    end else begin
      in_q     <= raw;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      to_q     <= to_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      derr_q   <= derr_d;
      stale_q  <= stale_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign digit_err = derr_q;
  assign stale     = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder
// Stimulus pushes expected frames; a negedge monitor pops and compares on each valid pulse.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic [15:0] data;
  logic        valid;
  logic [3:0]  digit_err;
  logic        stale;

  seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .anodes    (anodes),
    .segments  (segments),
    .data      (data),
    .valid     (valid),
    .digit_err (digit_err),
    .stale     (stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  e;
    int          c;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b1111110;
      4'h1: enc = 7'b0110000;
      4'h2: enc = 7'b1101101;
      4'h3: enc = 7'b1111001;
      4'h4: enc = 7'b0110011;
      4'h5: enc = 7'b1011011;
      4'h6: enc = 7'b1011111;
      4'h7: enc = 7'b1110000;
      4'h8: enc = 7'b1111111;
      4'h9: enc = 7'b1111011;
      4'hA: enc = 7'b1110111;
      4'hB: enc = 7'b0011111;
      4'hC: enc = 7'b1001110;
      4'hD: enc = 7'b0111101;
      4'hE: enc = 7'b1001111;
      default: enc = 7'b1000111;
    endcase
  endfunction

  // Called at a negedge; inputs take effect at the next posedge.
  task automatic apply(input logic [3:0] a, input logic [6:0] s, input int n);
    anodes   = a;
    segments = s;
    repeat (n) @(negedge clk);
  endtask

  // Call immediately before applying the frame's final digit.
  task automatic expect_frame(input logic [15:0] d, input logic [3:0] e);
    exp_t x;
    x.d = d;
    x.e = e;
    x.c = cyc + 6;
    sb.push_back(x);
  endtask

  task automatic send_frame(input logic [15:0] v);
    for (int d = 0; d < 3; d++) apply(4'(1 << d), enc(v[4*d +: 4]), 10);
    expect_frame(v, 4'b0000);
    apply(4'b1000, enc(v[15:12]), 10);
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got pulse with data %h, expected none", data);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("data", 32'(data), 32'(x.d));
        check("digit_err", 32'(digit_err), 32'(x.e));
        check("valid_latency", 32'(cyc), 32'(x.c));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    anodes   = 4'b0000;
    segments = 7'b0000000;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_digit_err", 32'(digit_err), 32'h0);
    check("reset_stale", 32'(stale), 32'h0);
    rst = 1'b0;

    send_frame(16'h1234);
    apply(4'b0000, 7'b0, 10);

    apply(4'b0001, enc(4'hF), 10);
    apply(4'b0010, enc(4'hE), 10);
    apply(4'b0100, 7'b1010101, 10);
    expect_frame(16'hB0EF, 4'b0100);
    apply(4'b1000, enc(4'hB), 10);
    apply(4'b0000, 7'b0, 10);

    apply(4'b0001, enc(4'hE), 10);
    apply(4'b0010, enc(4'h8), 3);
    apply(4'b0010, enc(4'hD), 10);
    apply(4'b0100, enc(4'h0), 10);
    expect_frame(16'hC0DE, 4'b0000);
    apply(4'b1000, enc(4'hC), 10);
    apply(4'b0000, 7'b0, 10);

    apply(4'b0011, enc(4'h5), 20);
    apply(4'b0000, 7'b0, 10);
    check("stale_after_ghost", 32'(stale), 32'h1);
    send_frame(16'h5A5A);
    check("stale_cleared_5a5a", 32'(stale), 32'h0);
    apply(4'b0000, 7'b0, 10);

    apply(4'b0001, enc(4'h6), 10);
    apply(4'b0010, enc(4'h7), 10);
    apply(4'b0100, enc(4'h8), 10);
    apply(4'b0000, 7'b0, 30);
    check("stale_timeout", 32'(stale), 32'h1);
    check("data_held_timeout", 32'(data), 32'h5A5A);
    // Digit 3 first: a partial frame that survived the timeout would complete here.
    apply(4'b1000, enc(4'h9), 10);
    apply(4'b0001, enc(4'h6), 10);
    apply(4'b0010, enc(4'h7), 10);
    expect_frame(16'h9876, 4'b0000);
    apply(4'b0100, enc(4'h8), 10);
    check("stale_cleared_9876", 32'(stale), 32'h0);
    apply(4'b0000, 7'b0, 10);

    apply(4'b0001, enc(4'h1), 10);
    apply(4'b0010, enc(4'h1), 10);
    apply(4'b0100, enc(4'h1), 10);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apply(4'b1000, enc(4'h1), 10);
    apply(4'b0000, 7'b0, 10);
    check("data_after_reset", 32'(data), 32'h0);
    check("digit_err_after_reset", 32'(digit_err), 32'h0);

    check("pending_frames", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
